// File: rtl/float_div_16bit.sv
// float_div_16bit: IEEE binary16 divider, restoring radix-2,
// one quotient bit per cycle, valid/ready on both sides.
package fpu_types_pkg;
  localparam int HALF_FLOAT_W    = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    ROUND,
    DONE
  } div_state_t;
endpackage

module float_div_16bit
  import fpu_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [HALF_FLOAT_W-1:0] dividend,
  input  logic [HALF_FLOAT_W-1:0] divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [HALF_FLOAT_W-1:0] quotient,
  output logic [4:0]              flags
);

  localparam int EW = HALF_EXPONENT_W;
  localparam int FW = HALF_FRACTION_W;

  div_state_t state, state_nx;

  logic [HALF_FLOAT_W-1:0] a_r, b_r;
  logic                    s_r;
  logic signed [6:0]       exp_r;
  logic [FW:0]             m2_r;
  logic [FW+1:0]           rem_r, q_r;
  logic [3:0]              cnt;
  logic [HALF_FLOAT_W-1:0] res_r;
  logic [4:0]              flg_r;

  function automatic logic [3:0] lzc11(input logic [FW:0] m);
    lzc11 = 4'd0;
    for (int i = 0; i <= FW; i++)
      if (m[i]) lzc11 = 4'(FW - i);
  endfunction

  logic [EW-1:0]     ea, eb;
  logic [FW-1:0]     fa, fb;
  logic              a_nan, a_inf, a_zero;
  logic              b_nan, b_inf, b_zero;
  logic [3:0]        sha, shb;
  logic [FW:0]       ma, mb;
  logic signed [6:0] xa, xb, exp_p;
  logic              lt;
  logic [FW+1:0]     m1_p;
  logic              s_x;
  logic              special;
  logic [15:0]       sp_res;
  logic [4:0]        sp_flg;

  assign ea = a_r[14:10];
  assign fa = a_r[9:0];
  assign eb = b_r[14:10];
  assign fb = b_r[9:0];
  assign s_x = a_r[15] ^ b_r[15];

  // Classify, normalize subnormals, form the biased quotient exponent
  always_comb begin
    a_nan  = (ea == 5'h1F) && (fa != 0);
    a_inf  = (ea == 5'h1F) && (fa == 0);
    a_zero = (ea == 5'h00) && (fa == 0);
    b_nan  = (eb == 5'h1F) && (fb != 0);
    b_inf  = (eb == 5'h1F) && (fb == 0);
    b_zero = (eb == 5'h00) && (fb == 0);
    sha = (ea == 0) ? lzc11({1'b0, fa}) : 4'd0;
    shb = (eb == 0) ? lzc11({1'b0, fb}) : 4'd0;
    ma = (ea == 0) ? ({1'b0, fa} << sha) : {1'b1, fa};
    mb = (eb == 0) ? ({1'b0, fb} << shb) : {1'b1, fb};
    xa = (ea == 0) ? 7'sd1 - $signed({3'b0, sha})
                   : $signed({2'b0, ea});
    xb = (eb == 0) ? 7'sd1 - $signed({3'b0, shb})
                   : $signed({2'b0, eb});
    lt = ma < mb;
    m1_p = lt ? {ma, 1'b0} : {1'b0, ma};
    exp_p = xa - xb + 7'sd15 - (lt ? 7'sd1 : 7'sd0);
  end

  // Special-operand results, highest priority first
  always_comb begin
    special = 1'b1;
    sp_res  = 16'h0000;
    sp_flg  = 5'b00000;
    if (a_nan || b_nan || (a_zero && b_zero) ||
        (a_inf && b_inf)) begin
      sp_res = 16'hFFFF;
      sp_flg = 5'b10000;
    end else if (b_zero && !a_inf) begin
      sp_res = {s_x, 5'h1F, 10'h000};
      sp_flg = 5'b01000;
    end else if (a_inf) begin
      sp_res = {s_x, 5'h1F, 10'h000};
    end else if (a_zero || b_inf) begin
      sp_res = 16'h0000;
    end else begin
      special = 1'b0;
    end
  end

  logic          ge;
  logic [FW+1:0] diff, rem_nx;

  // One restoring-division step
  always_comb begin
    ge     = rem_r >= {1'b0, m2_r};
    diff   = ge ? rem_r - {1'b0, m2_r} : rem_r;
    rem_nx = diff << 1;
  end

  logic signed [6:0] sh;
  logic [FW+1:0]     qs;
  logic              lost, g, nx;
  logic [EW-1:0]     ef;
  logic [14:0]       sum;
  logic [15:0]       rnd_res;
  logic [4:0]        rnd_flg;

  // Denormalize, round half-up on guard, detect overflow/underflow
  always_comb begin
    sh      = 7'sd0;
    qs      = q_r;
    lost    = 1'b0;
    ef      = exp_r[4:0];
    g       = 1'b0;
    nx      = 1'b0;
    sum     = 15'd0;
    rnd_res = 16'h0000;
    rnd_flg = 5'b00000;
    if (exp_r >= 7'sd31) begin
      rnd_res = {s_r, 5'h1F, 10'h000};
      rnd_flg = 5'b00101;
    end else begin
      if (exp_r <= 7'sd0) begin
        sh = 7'sd1 - exp_r;
        ef = 5'd0;
        if (sh > 7'sd12) begin
          qs   = '0;
          lost = 1'b1;
        end else begin
          qs   = q_r >> sh;
          lost = |(q_r & ~(12'hFFF << sh));
        end
      end
      g   = qs[0];
      nx  = g | lost | (|rem_r);
      sum = {ef, qs[10:1]} + {14'd0, g};
      rnd_res = {s_r, sum};
      rnd_flg = {2'b00, sum[14:10] == 5'h1F,
                 (sum[14:10] == 5'h00) && nx, nx};
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (in_valid) state_nx = PREP;
      PREP:  state_nx = special ? DONE : ITER;
      ITER:  if (cnt == 4'd11) state_nx = ROUND;
      ROUND: state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs; results are gated to zero when not valid
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    quotient  = out_valid ? res_r : 16'h0000;
    flags     = out_valid ? flg_r : 5'b00000;
  end

  // Operand capture and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= 1'b0;
      exp_r <= '0;
      m2_r  <= '0;
      rem_r <= '0;
      q_r   <= '0;
      cnt   <= '0;
      res_r <= '0;
      flg_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= dividend;
            b_r <= divisor;
          end
        end
        PREP: begin
          s_r   <= s_x;
          exp_r <= exp_p;
          m2_r  <= mb;
          rem_r <= m1_p;
          q_r   <= '0;
          cnt   <= '0;
          if (special) begin
            res_r <= sp_res;
            flg_r <= sp_flg;
          end
        end
        ITER: begin
          q_r   <= {q_r[10:0], ge};
          rem_r <= rem_nx;
          cnt   <= cnt + 4'd1;
        end
        ROUND: begin
          res_r <= rnd_res;
          flg_r <= rnd_flg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_16bit.sv
// tb_float_div_16bit: directed and random checks of the
// binary16 divider against a real-arithmetic reference.
module tb_float_div_16bit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] dividend = 16'h0;
  logic [15:0] divisor = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [4:0]  flags;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  float_div_16bit dut (
    .CLK(CLK),
    .nRST(nRST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .flags(flags)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real p2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [15:0] h);
    int e;
    int f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return $itor(f) * p2(-24);
    return $itor(1024 + f) * p2(e - 25);
  endfunction

  // Reference: exact real quotient, rounded half-up on magnitude
  task automatic model(input logic [15:0] a,
                       input logic [15:0] b,
                       output logic [15:0] q,
                       output logic [4:0] fl,
                       output int lat);
    logic an, ai, az, bn, bi, bz, s;
    real x, y, n, fr;
    int e, k, base, bits;
    logic nxf;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    az = (a[14:0] == 0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    bz = (b[14:0] == 0);
    s  = a[15] ^ b[15];
    lat = 1;
    fl  = 5'b00000;
    q   = 16'h0000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      q = 16'hFFFF;
      fl = 5'b10000;
    end else if (bz && !ai) begin
      q = {s, 15'h7C00};
      fl = 5'b01000;
    end else if (ai) begin
      q = {s, 15'h7C00};
    end else if (az || bi) begin
      q = 16'h0000;
    end else begin
      lat = 14;
      x = mag(a) / mag(b);
      if (x >= 65520.0) begin
        q = {s, 15'h7C00};
        fl = 5'b00101;
      end else begin
        if (x < p2(-14)) begin
          n = x * p2(24);
          base = 0;
        end else begin
          y = x;
          e = 0;
          while (y >= 2.0) begin y = y / 2.0; e++; end
          while (y < 1.0) begin y = y * 2.0; e--; end
          n = x / p2(e - 10);
          base = ((e + 15) << 10) - 1024;
        end
        k = $rtoi(n);
        fr = n - $itor(k);
        if (fr >= 0.5) k++;
        bits = base + k;
        nxf = (fr != 0.0);
        if (bits >= 32'h7C00) begin
          q = {s, 15'h7C00};
          fl = 5'b00101;
        end else begin
          q = {s, 15'(bits)};
          fl = {3'b000, (bits < 1024) && nxf, nxf};
        end
      end
    end
  endtask

  task automatic issue(input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge CLK);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
  endtask

  task automatic await(input string tag,
                       input logic [15:0] eq,
                       input logic [4:0] ef,
                       input int el);
    int n;
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!out_valid && n < 40);
    chk({tag, " latency"}, n, el);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " flags"}, flags, ef);
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({tag, " cleared"},
        {out_valid, quotient, flags}, 0);
  endtask

  task automatic run(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] eq,
                     input logic [4:0] ef,
                     input int el);
    issue(a, b);
    await(tag, eq, ef, el);
    retire(tag);
  endtask

  initial begin
    logic [15:0] a, b, eq;
    logic [4:0]  ef;
    int          el, seen, mode;

    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", {in_ready, out_valid, quotient, flags},
        {1'b1, 22'd0});
    @(negedge CLK);
    nRST = 1'b1;

    run("one_by_two", 16'h3C00, 16'h4000, 16'h3800, 5'b00000, 14);
    run("one_by_three", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 14);
    run("three_by_two", 16'h4200, 16'h4000, 16'h3E00, 5'b00000, 14);
    run("div_zero", 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1);
    run("zero_zero", 16'h0000, 16'h0000, 16'hFFFF, 5'b10000, 1);
    run("overflow", 16'h7BFF, 16'h0001, 16'h7C00, 5'b00101, 14);
    run("under_tie", 16'h0001, 16'h4000, 16'h0001, 5'b00011, 14);
    run("snan", 16'h7D00, 16'h3C00, 16'hFFFF, 5'b10000, 1);
    run("inf_fin", 16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 1);
    run("fin_inf", 16'h4000, 16'h7C00, 16'h0000, 5'b00000, 1);

    issue(16'h4400, 16'h4000);
    await("hold", 16'h4000, 5'b00000, 14);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor = 16'($urandom);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      chk("hold_stable", {in_ready, out_valid, quotient},
          {1'b0, 1'b1, 16'h4000});
    end
    retire("hold");

    issue(16'h4400, 16'h4000);
    repeat (6) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_iter_reset", {in_ready, out_valid, quotient, flags},
        {1'b1, 22'd0});
    @(negedge CLK);
    nRST = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid) seen++;
    end
    chk("no_stale", seen, 0);
    run("after_reset", 16'h4400, 16'h4000, 16'h4000, 5'b00000, 14);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        a[14:10] = 5'($urandom_range(10, 20));
        b[14:10] = 5'($urandom_range(10, 20));
      end else if (mode == 2) begin
        a[14:10] = 5'($urandom_range(0, 6));
        b[14:10] = 5'($urandom_range(16, 30));
      end else if (mode == 3) begin
        a[14:10] = 5'($urandom_range(24, 30));
        b[14:10] = 5'($urandom_range(0, 8));
      end
      model(a, b, eq, ef, el);
      run($sformatf("rand %h/%h", a, b), a, b, eq, ef, el);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/float_div_16bit.md
FLOAT_DIV_16BIT -- requirements
Module: float_div_16bit

Interface
REQ-001 Parameters SHALL be none; widths come from fpu_types_pkg (HALF_FLOAT_W=16, HALF_EXPONENT_W=5, HALF_FRACTION_W=10).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  operand pair valid.
REQ-006 in_ready  out  1  divider idle; accepts an operand pair.
REQ-007 dividend  in  16  IEEE binary16 numerator.
REQ-008 divisor  in  16  IEEE binary16 denominator.
REQ-009 out_valid  out  1  quotient valid.
REQ-010 out_ready  in  1  consumer accepts the quotient.
REQ-011 quotient  out  16  IEEE binary16 result.
REQ-012 flags  out  5  {NV,DZ,OF,UF,NX}; valid with out_valid.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, PREP, ITER, ROUND and DONE.
REQ-014 in_ready SHALL equal (state==IDLE); an accept is in_valid&in_ready at a rising edge, and operands are registered at that edge.
REQ-015 Operand inputs SHALL be ignored outside an accept edge.
REQ-016 PREP (1 cycle) SHALL classify operands, normalize subnormals by leading-one shift, and compute exp = e1 - e2 + 15 in 7-bit signed, using e=1-shift for subnormals.
REQ-017 Special results SHALL go from PREP to DONE with priority as listed.
REQ-017a NaN operand, 0/0 or inf/inf SHALL give 16'hFFFF with NV; an SNaN operand also gives 16'hFFFF.
REQ-017b finite nonzero/0 SHALL give {s1^s2,5'h1F,10'h0} with DZ.
REQ-017c inf/finite SHALL give {s1^s2,5'h1F,10'h0} with no flags.
REQ-017d 0/finite nonzero or finite/inf SHALL give 16'h0000 with no flags.
REQ-018 In PREP, when mant1 < mant2, the dividend mantissa SHALL be pre-shifted left one bit and exp decremented by one.
REQ-019 ITER SHALL run a 4-bit counter for exactly 12 cycles of radix-2 restoring division, producing one quotient bit per cycle (1 integer, 10 fraction, 1 guard); sticky = (final remainder != 0).
REQ-020 ROUND (1 cycle), overflow: exp >= 31 SHALL give {s,5'h1F,0} with OF|NX.
REQ-021 ROUND, underflow: exp <= 0 SHALL right-shift the 12-bit quotient by (1-exp), folding shifted-out bits into sticky, and set exp field 0; a shift > 12 SHALL give signed zero with UF|NX.
REQ-022 Rounding SHALL be round-half-up on the guard bit, matching float_mult_16bit.
REQ-023 A mantissa carry from rounding SHALL increment exp (subnormal to min normal allowed); if exp becomes 31 the result SHALL be inf with OF.
REQ-024 NX SHALL equal guard|sticky; UF SHALL be set when the result is subnormal or zero and NX=1.
REQ-025 Latency SHALL be: accept at edge k gives out_valid high after edge k+14 (normal/subnormal) or after edge k+1 (special).
REQ-026 DONE SHALL hold quotient, flags and out_valid stable until out_valid&out_ready, then go to IDLE at that edge.
REQ-027 in_ready SHALL remain 0 during the return from DONE; no same-cycle reaccept.
REQ-028 quotient and flags SHALL read 0 whenever out_valid=0.

Reset
REQ-029 nRST low SHALL immediately force state=IDLE, counter=0, out_valid=0, quotient=0, flags=0, in_ready=1, at any point including mid-ITER.
REQ-030 After reset, no stale result SHALL be emitted and the first accept SHALL behave per REQ-025.

Verification
REQ-031 3C00/4000 -> 3800, flags 00000, out_valid after edge k+14.
REQ-032 3C00/4200 -> 3555 with NX; 4200/4000 -> 3E00 with flags 0.
REQ-033 3C00/0000 -> 7C00 with DZ; 0000/0000 -> FFFF with NV; both with out_valid after edge k+1.
REQ-034 7BFF/0001 -> 7C00 with OF|NX; 0001/4000 -> 0001 with UF|NX (tie rounds up).
REQ-035 out_ready held low 10 cycles in DONE -> quotient stable and in_ready=0; in_valid pulses in that window are ignored.
REQ-036 nRST asserted at ITER cycle 6 -> outputs zero immediately; after release, the next accept of 4400/4000 -> 4000.
